mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-port, 1-cycle-read-latency word memory between three requesters: the CPU data port (MEM stage), the CPU instruction-fetch port, and an external DMA/loader port. Fixed priority is data > instruction > DMA, with a starvation guard that lets a waiting DMA request win over fetch. Responses are pipelined: a new access is granted every cycle, and its response returns exactly one cycle after the grant. The block also drives a stall to the pipeline and flags out-of-range addresses.

Parameters:
MEM_TOP, 32'h0000007c, highest legal byte address; any address above it faults.
STARVE_LIMIT, 4, number of consecutive denied DMA cycles after which DMA outranks fetch.
CW, 3, width of the starvation counter; must satisfy 2^CW > STARVE_LIMIT.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
i_req  input  1  fetch request (always a read)
i_addr  input  32  fetch byte address
i_gnt  output  1  fetch granted this cycle
i_rvalid  output  1  fetch response valid
i_rdata  output  32  fetch read data
i_err  output  1  fetch fault, qualified by i_rvalid
d_req  input  1  data request
d_we  input  4  byte write enables; 0 means read
d_addr  input  32  data byte address
d_wdata  input  32  data write data
d_gnt  output  1  data granted this cycle
d_rvalid  output  1  data response or write acknowledge
d_rdata  output  32  data read data
d_err  output  1  data fault, qualified by d_rvalid
x_req  input  1  DMA request
x_we  input  4  DMA byte enables; 0 means read
x_addr  input  32  DMA byte address
x_wdata  input  32  DMA write data
x_gnt  output  1  DMA granted this cycle
x_rvalid  output  1  DMA response valid
x_rdata  output  32  DMA read data
x_err  output  1  DMA fault, qualified by x_rvalid
m_en  output  1  memory access enable
m_we  output  4  memory byte write enables
m_addr  output  32  memory byte address
m_wdata  output  32  memory write data
m_rdata  input  32  memory read data, valid one cycle after m_en
cpu_stall  output  1  CPU pipeline must hold

Behaviour:
- Reset (rst=0, asynchronous):
  - All *_gnt, *_rvalid, *_err, m_en and cpu_stall are forced to 0; m_we is forced to 0.
  - Response tag register is cleared to NONE, and the starvation counter is cleared to 0.
  - Reset is honoured mid-access: an in-flight response is dropped and no rvalid is issued after reset is released.
- Grant (combinational, at most one per cycle):
  - Data wins whenever d_req=1.
  - Otherwise DMA wins if x_req=1 and starve_cnt >= STARVE_LIMIT.
  - Otherwise fetch wins if i_req=1.
  - Otherwise DMA wins if x_req=1.
- Memory command:
  - In a grant cycle, m_addr, m_we and m_wdata are taken from the winner; m_we is zeroed for fetch.
  - m_en=1 only if the winner's address <= MEM_TOP.
  - An out-of-range address is still granted, but m_en=0 and m_we=0, so memory is not touched.
  - With no grant: m_en=0, m_we=0; m_addr and m_wdata hold their last values.
- Response pipeline:
  - On each clock the registers resp_owner {NONE, I, D, X}, resp_write and resp_fault are loaded from the current grant.
  - Next cycle, the owner's rvalid=1 and its err=resp_fault.
  - Its rdata=m_rdata for a good read, and 32'h0 for a write or a fault.
  - Non-owner rvalid, err and rdata are 0.
  - Back-to-back grants produce back-to-back responses with no bubble.
- Starvation counter:
  - Resets to 0 on any cycle with x_gnt=1 or x_req=0.
  - Increments when x_req=1 and x_gnt=0.
  - Saturates at STARVE_LIMIT.
- cpu_stall = (i_req & ~i_gnt) | (d_req & ~d_gnt). The data port is never stalled by the arbiter, so effectively the stall comes from the fetch side.
- Byte addressing: the low two bits of the address are passed through unchanged. The byte-lane alignment is the requester's job.
- A requester must hold *_req and its address/data stable until it sees *_gnt. Dropping a request before grant is legal and produces no response.

Test Plan:
1. Reset release, idle -> all outputs 0. Then i_req=1, i_addr=0x10 -> i_gnt=1, m_en=1, m_addr=0x10 that cycle; next cycle i_rvalid=1, i_rdata=m_rdata, i_err=0.
2. d_req (d_we=4'hF, d_addr=0x20, d_wdata=0xDEADBEEF) and i_req in the same cycle -> d_gnt=1, i_gnt=0, cpu_stall=1, m_we=4'hF. Next cycle d_rvalid=1, d_rdata=0, and the fetch is granted.
3. i_req and x_req held for 6 cycles -> i granted cycles 0..3; cycle 4 (starve_cnt=4) x_gnt=1, i_gnt=0, cpu_stall=1; starve_cnt back to 0; cycle 5 i granted again.
4. d_req read at d_addr=0x80 -> d_gnt=1, m_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
5. Alternating d and i grants every cycle -> rvalid toggles between d and i exactly one cycle after each grant, each with the correct m_rdata.
6. rst asserted the cycle after a grant -> no rvalid is ever issued for that grant; starve_cnt=0 after release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and stall signals of the shared single-port memory arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        x_req;
    logic [3:0]  x_we;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_gnt;
    logic        x_rvalid;
    logic [31:0] x_rdata;
    logic        x_err;

    logic        m_en;
    logic [3:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    logic        cpu_stall;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  x_req, x_we, x_addr, x_wdata,
        input  m_rdata,
        output i_gnt, i_rvalid, i_rdata, i_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output x_gnt, x_rvalid, x_rdata, x_err,
        output m_en, m_we, m_addr, m_wdata,
        output cpu_stall
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output x_req, x_we, x_addr, x_wdata,
        output m_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  x_gnt, x_rvalid, x_rdata, x_err,
        input  m_en, m_we, m_addr, m_wdata,
        input  cpu_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter (data > fetch > DMA, with DMA starvation guard) in front of a
// single-port, 1-cycle-latency memory; responses return exactly one cycle after grant.
module mem_port_arbiter #(
    parameter logic [31:0] MEM_TOP      = 32'h0000_007c,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CW           = 3
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        OwnNone,
        OwnFetch,
        OwnData,
        OwnDma
    } owner_e;

    localparam logic [CW-1:0] StarveMax = CW'(STARVE_LIMIT);

    owner_e        owner_q, owner_d;
    logic          write_q, write_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;

    logic          sel_fetch, sel_data, sel_dma, any_sel;
    logic [31:0]   win_addr, win_wdata;
    logic [3:0]    win_we;
    logic          in_range;
    logic          good_read;

    // Grant decision; everything is held off while reset is asserted.
    always_comb begin
        sel_fetch = 1'b0;
        sel_data  = 1'b0;
        sel_dma   = 1'b0;
        if (rst) begin
            if (bus.d_req) begin
                sel_data = 1'b1;
            end else if (bus.x_req && (starve_q >= StarveMax)) begin
                sel_dma = 1'b1;
            end else if (bus.i_req) begin
                sel_fetch = 1'b1;
            end else if (bus.x_req) begin
                sel_dma = 1'b1;
            end
        end
    end

    assign any_sel = sel_fetch | sel_data | sel_dma;

    // Winner command mux; address and write data hold their last values when idle.
    always_comb begin
        win_addr  = m_addr_q;
        win_wdata = m_wdata_q;
        win_we    = 4'h0;
        if (sel_data) begin
            win_addr  = bus.d_addr;
            win_wdata = bus.d_wdata;
            win_we    = bus.d_we;
        end else if (sel_dma) begin
            win_addr  = bus.x_addr;
            win_wdata = bus.x_wdata;
            win_we    = bus.x_we;
        end else if (sel_fetch) begin
            win_addr  = bus.i_addr;
        end
    end

    assign in_range = (win_addr <= MEM_TOP);

    // Out-of-range accesses are granted but never reach the memory.
    assign bus.m_en    = any_sel & in_range;
    assign bus.m_we    = (any_sel && in_range) ? win_we : 4'h0;
    assign bus.m_addr  = win_addr;
    assign bus.m_wdata = win_wdata;

    assign bus.i_gnt = sel_fetch;
    assign bus.d_gnt = sel_data;
    assign bus.x_gnt = sel_dma;

    assign bus.cpu_stall = rst & ((bus.i_req & ~sel_fetch) | (bus.d_req & ~sel_data));

    always_comb begin
        owner_d = OwnNone;
        if (sel_data) begin
            owner_d = OwnData;
        end else if (sel_dma) begin
            owner_d = OwnDma;
        end else if (sel_fetch) begin
            owner_d = OwnFetch;
        end
        write_d   = any_sel & (win_we != 4'h0);
        fault_d   = any_sel & ~in_range;
        m_addr_d  = win_addr;
        m_wdata_d = win_wdata;
    end

    // DMA starvation: count consecutive denied cycles, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!bus.x_req || sel_dma) begin
            starve_d = '0;
        end else if (starve_q < StarveMax) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q   <= OwnNone;
            write_q   <= 1'b0;
            fault_q   <= 1'b0;
            starve_q  <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            owner_q   <= owner_d;
            write_q   <= write_d;
            fault_q   <= fault_d;
            starve_q  <= starve_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    // Writes and faults return zero data; only a good read forwards the memory word.
    assign good_read = ~write_q & ~fault_q;

    assign bus.i_rvalid = (owner_q == OwnFetch);
    assign bus.i_err    = (owner_q == OwnFetch) & fault_q;
    assign bus.i_rdata  = ((owner_q == OwnFetch) && good_read) ? bus.m_rdata : 32'h0;

    assign bus.d_rvalid = (owner_q == OwnData);
    assign bus.d_err    = (owner_q == OwnData) & fault_q;
    assign bus.d_rdata  = ((owner_q == OwnData) && good_read) ? bus.m_rdata : 32'h0;

    assign bus.x_rvalid = (owner_q == OwnDma);
    assign bus.x_err    = (owner_q == OwnDma) & fault_q;
    assign bus.x_rdata  = ((owner_q == OwnDma) && good_read) ? bus.m_rdata : 32'h0;

endmodule
